// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// The ALU block decodes the same ALUControl codes defined here.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_UNK = 3'b011;
  localparam logic [2:0] ALUC_NOR = 3'b100;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcwrite;
    logic       branch;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps (ALUOp, Funct) to the ALUControl code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // ALUOp selects a fixed operation, or hands the choice to the funct field
  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUC_ADD;
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          FN_NOR:  alucontrol = ALUC_NOR;
          default: alucontrol = ALUC_UNK;
        endcase
      end
      default: alucontrol = ALUC_UNK;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl_chk.sv
// Protocol checker for the control unit; carries assertions only, no logic.
module mips_multicycle_ctrl_chk
  import mips_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  input logic [3:0] state,
  input logic       pcen,
  input logic       memwrite,
  input logic       illegal
);

  a_fetch_to_decode: assert property (@(posedge clk) disable iff (!reset_n)
    (state == S_FETCH) |=> (state == S_DECODE));

  a_fetch_pcen_once: assert property (@(posedge clk) disable iff (!reset_n)
    (state == S_FETCH) |=> !pcen);

  a_memwrite_state: assert property (@(posedge clk) disable iff (!reset_n)
    memwrite |-> (state == S_MEMWR));

  a_illegal_state: assert property (@(posedge clk) disable iff (!reset_n)
    illegal |-> (state == S_DECODE));

  a_halt_absorbs: assert property (@(posedge clk) disable iff (!reset_n)
    (state == S_HALT) |=> (state == S_HALT));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared datapath selects and write enables.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter logic HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state_r;
  state_t     next_s;
  ctrl_t      ctrl_s;
  logic       illegal_s;
  logic [2:0] aluctl_s;

  // State register; reset lands directly in FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: next_s = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_RTYPEEX;
          OP_BEQ:       next_s = S_BEQEX;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JEX;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              next_s = S_HALT;
            end else begin
              next_s = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_SW) begin
          next_s = S_MEMWR;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMRD:   next_s = S_MEMWB;
      S_MEMWB:   next_s = S_FETCH;
      S_MEMWR:   next_s = S_FETCH;
      S_RTYPEEX: next_s = S_RTYPEWB;
      S_RTYPEWB: next_s = S_FETCH;
      S_ADDIEX:  next_s = S_ADDIWB;
      S_ADDIWB:  next_s = S_FETCH;
      S_BEQEX:   next_s = S_FETCH;
      S_JEX:     next_s = S_FETCH;
      S_HALT:    next_s = S_HALT;
      default:   next_s = S_FETCH;
    endcase
  end

  // Moore output decode; anything not set here stays deasserted
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      S_FETCH: begin
        ctrl_s.irwrite = 1'b1;
        ctrl_s.alusrcb = SRCB_FOUR;
        ctrl_s.aluop   = ALUOP_ADD;
        ctrl_s.pcsrc   = PCSRC_ALU;
        ctrl_s.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl_s.alusrcb = SRCB_BOFS;
        ctrl_s.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_s.iord = 1'b1;
      S_MEMWR: begin
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_B;
        ctrl_s.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      S_ADDIWB: ctrl_s.regwrite = 1'b1;
      S_BEQEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_B;
        ctrl_s.aluop   = ALUOP_SUB;
        ctrl_s.pcsrc   = PCSRC_OUT;
        ctrl_s.branch  = 1'b1;
      end
      S_JEX: begin
        ctrl_s.pcsrc   = PCSRC_JUMP;
        ctrl_s.pcwrite = 1'b1;
      end
      S_HALT:  ctrl_s = '0;
      default: ctrl_s = '0;
    endcase
  end

  // Illegal opcode flag is a DECODE-only indication
  always_comb begin
    if (state_r == S_DECODE) begin
      illegal_s = !op_is_legal(Op);
    end else begin
      illegal_s = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_s.aluop),
    .funct      (Funct),
    .alucontrol (aluctl_s)
  );

  // Write-type outputs are held off while reset is asserted, independent of the clock
  assign IRWrite  = ctrl_s.irwrite  & reset_n;
  assign MemWrite = ctrl_s.memwrite & reset_n;
  assign RegWrite = ctrl_s.regwrite & reset_n;
  assign PCEn     = (ctrl_s.pcwrite | (ctrl_s.branch & Zero)) & reset_n;
  assign Illegal  = illegal_s & reset_n;

  assign ALUControl = aluctl_s;
  assign ALUSrcA    = ctrl_s.alusrca;
  assign ALUSrcB    = ctrl_s.alusrcb;
  assign PCSrc      = ctrl_s.pcsrc;
  assign IorD       = ctrl_s.iord;
  assign RegDst     = ctrl_s.regdst;
  assign MemtoReg   = ctrl_s.memtoreg;
  assign State      = state_r;

  mips_multicycle_ctrl_chk u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .state    (state_r),
    .pcen     (PCEn),
    .memwrite (MemWrite),
    .illegal  (Illegal)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a cycle-by-cycle vector table plus
// hand sequences for illegal-opcode halt and reset in the middle of a store.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] Op = 6'b100011;
  logic [5:0] Funct = 6'b000000;
  logic       Zero = 1'b0;

  logic [3:0] st0, st1;
  logic [2:0] aluc0, aluc1;
  logic       srca0, srca1;
  logic [1:0] srcb0, srcb1, pcsrc0, pcsrc1;
  logic       iord0, irw0, mw0, rw0, rd0, mtr0, pcen0, ill0;
  logic       iord1, irw1, mw1, rw1, rd1, mtr1, pcen1, ill1;

  logic [19:0] obs0, obs1;
  assign obs0 = {st0, aluc0, srca0, srcb0, pcsrc0, iord0, irw0, mw0, rw0, rd0, mtr0, pcen0, ill0};
  assign obs1 = {st1, aluc1, srca1, srcb1, pcsrc1, iord1, irw1, mw1, rw1, rd1, mtr1, pcen1, ill1};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUControl(aluc0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .PCSrc(pcsrc0),
    .IorD(iord0), .IRWrite(irw0), .MemWrite(mw0), .RegWrite(rw0),
    .RegDst(rd0), .MemtoReg(mtr0), .PCEn(pcen0), .Illegal(ill0), .State(st0)
  );

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUControl(aluc1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCSrc(pcsrc1),
    .IorD(iord1), .IRWrite(irw1), .MemWrite(mw1), .RegWrite(rw1),
    .RegDst(rd1), .MemtoReg(mtr1), .PCEn(pcen1), .Illegal(ill1), .State(st1)
  );

  // Expected vectors: {State, ALUControl, ALUSrcA, ALUSrcB, PCSrc,
  //   IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn, Illegal}
  localparam logic [19:0] E_RST   = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_FETCH = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b0100_0010};
  localparam logic [19:0] E_DEC   = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_DECI  = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0001};
  localparam logic [19:0] E_MADR  = {4'd2,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_MRD   = {4'd3,  3'b010, 1'b0, 2'b00, 2'b00, 8'b1000_0000};
  localparam logic [19:0] E_MWB   = {4'd4,  3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_0100};
  localparam logic [19:0] E_MWR   = {4'd5,  3'b010, 1'b0, 2'b00, 2'b00, 8'b1010_0000};
  localparam logic [19:0] E_RTSUB = {4'd6,  3'b110, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_RTUNK = {4'd6,  3'b011, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_RTSLT = {4'd6,  3'b111, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_RTWB  = {4'd7,  3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_1000};
  localparam logic [19:0] E_BEQ1  = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0010};
  localparam logic [19:0] E_BEQ0  = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};
  localparam logic [19:0] E_AEX   = {4'd9,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [19:0] E_AWB   = {4'd10, 3'b010, 1'b0, 2'b00, 2'b00, 8'b0001_0000};
  localparam logic [19:0] E_JEX   = {4'd11, 3'b010, 1'b0, 2'b00, 2'b10, 8'b0000_0010};
  localparam logic [19:0] E_HALT  = {4'd12, 3'b010, 1'b0, 2'b00, 2'b00, 8'b0000_0000};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [19:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.funct = fn; v.zero = z; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input logic z);
    @(posedge clk); #1;
    reset_n = r; Op = op; Zero = z;
    @(negedge clk);
  endtask

  initial begin
    add(1'b0, LW, 6'h00, 1'b0, E_RST,   "rst0");
    add(1'b0, LW, 6'h00, 1'b0, E_RST,   "rst1");
    add(1'b0, LW, 6'h00, 1'b0, E_RST,   "rst2");
    add(1'b1, LW, 6'h00, 1'b0, E_FETCH, "lw_fetch");
    add(1'b1, LW, 6'h00, 1'b0, E_DEC,   "lw_decode");
    add(1'b1, LW, 6'h00, 1'b0, E_MADR,  "lw_memadr");
    add(1'b1, LW, 6'h00, 1'b0, E_MRD,   "lw_memrd");
    add(1'b1, LW, 6'h00, 1'b0, E_MWB,   "lw_memwb");
    add(1'b1, RT, 6'b100010, 1'b0, E_FETCH, "sub_fetch");
    add(1'b1, RT, 6'b100010, 1'b0, E_DEC,   "sub_decode");
    add(1'b1, RT, 6'b100010, 1'b0, E_RTSUB, "sub_ex");
    add(1'b1, RT, 6'b100010, 1'b0, E_RTWB,  "sub_wb");
    add(1'b1, RT, 6'b111111, 1'b0, E_FETCH, "unk_fetch");
    add(1'b1, RT, 6'b111111, 1'b0, E_DEC,   "unk_decode");
    add(1'b1, RT, 6'b111111, 1'b0, E_RTUNK, "unk_ex");
    add(1'b1, RT, 6'b111111, 1'b0, E_RTWB,  "unk_wb");
    add(1'b1, RT, 6'b101010, 1'b0, E_FETCH, "slt_fetch");
    add(1'b1, RT, 6'b101010, 1'b0, E_DEC,   "slt_decode");
    add(1'b1, RT, 6'b101010, 1'b0, E_RTSLT, "slt_ex");
    add(1'b1, RT, 6'b101010, 1'b0, E_RTWB,  "slt_wb");
    add(1'b1, ADDI, 6'h00, 1'b1, E_FETCH, "addi_fetch");
    add(1'b1, ADDI, 6'h00, 1'b1, E_DEC,   "addi_decode");
    add(1'b1, ADDI, 6'h00, 1'b1, E_AEX,   "addi_ex");
    add(1'b1, ADDI, 6'h00, 1'b1, E_AWB,   "addi_wb");
    add(1'b1, BEQ, 6'h00, 1'b1, E_FETCH, "beqt_fetch");
    add(1'b1, BEQ, 6'h00, 1'b1, E_DEC,   "beqt_decode");
    add(1'b1, BEQ, 6'h00, 1'b1, E_BEQ1,  "beqt_ex");
    add(1'b1, BEQ, 6'h00, 1'b0, E_FETCH, "beqn_fetch");
    add(1'b1, BEQ, 6'h00, 1'b0, E_DEC,   "beqn_decode");
    add(1'b1, BEQ, 6'h00, 1'b0, E_BEQ0,  "beqn_ex");
    add(1'b1, SW, 6'h00, 1'b0, E_FETCH, "sw_fetch");
    add(1'b1, SW, 6'h00, 1'b0, E_DEC,   "sw_decode");
    add(1'b1, SW, 6'h00, 1'b0, E_MADR,  "sw_memadr");
    add(1'b1, SW, 6'h00, 1'b0, E_MWR,   "sw_memwr");
    add(1'b1, J,  6'h00, 1'b0, E_FETCH, "j_fetch");
    add(1'b1, J,  6'h00, 1'b0, E_DEC,   "j_decode");
    add(1'b1, J,  6'h00, 1'b0, E_JEX,   "j_ex");
    add(1'b1, BAD, 6'h00, 1'b0, E_FETCH, "ill_fetch");
    add(1'b1, BAD, 6'h00, 1'b0, E_DECI,  "ill_decode");
    add(1'b1, BAD, 6'h00, 1'b0, E_FETCH, "ill_refetch");

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset_n = vecs[i].rst;
      Op      = vecs[i].op;
      Funct   = vecs[i].funct;
      Zero    = vecs[i].zero;
      @(negedge clk);
      check(vecs[i].name, obs0, vecs[i].exp);
    end

    // Illegal opcode: HALT_ON_ILLEGAL=1 instance must stick in HALT until reset
    Funct = 6'h00;
    cyc(1'b0, BAD, 1'b0); check("halt_rst0", obs0, E_RST); check("halt_rst1", obs1, E_RST);
    cyc(1'b1, BAD, 1'b0); check("halt_fetch", obs1, E_FETCH);
    cyc(1'b1, BAD, 1'b0); check("halt_decode1", obs1, E_DECI); check("halt_decode0", obs0, E_DECI);
    cyc(1'b1, BAD, 1'b1); check("halt_enter", obs1, E_HALT); check("nohalt_fetch", obs0, E_FETCH);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, J, 1'b1);
      check($sformatf("halt_stay%0d", k), obs1, E_HALT);
    end
    cyc(1'b0, J, 1'b0); check("halt_reset", obs1, E_RST);
    cyc(1'b1, J, 1'b0); check("halt_exit", obs1, E_FETCH);

    // Reset arriving mid-MEMWR: write drops at once, restart from FETCH
    cyc(1'b0, SW, 1'b0);
    cyc(1'b1, SW, 1'b0); check("mr_fetch", obs0, E_FETCH);
    cyc(1'b1, SW, 1'b0); check("mr_decode", obs0, E_DEC);
    cyc(1'b1, SW, 1'b0); check("mr_memadr", obs0, E_MADR);
    cyc(1'b1, SW, 1'b0); check("mr_memwr", obs0, E_MWR);
    #2 reset_n = 1'b0;
    #1 check("mr_async", obs0, E_RST);
    cyc(1'b1, LW, 1'b0); check("mr_refetch", obs0, E_FETCH);
    cyc(1'b1, LW, 1'b0); check("mr_lw_decode", obs0, E_DEC);
    cyc(1'b1, LW, 1'b0); check("mr_lw_memadr", obs0, E_MADR);
    cyc(1'b1, LW, 1'b0); check("mr_lw_memrd", obs0, E_MRD);
    cyc(1'b1, LW, 1'b0); check("mr_lw_memwb", obs0, E_MWB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
